kim_stream_src: RTL and testbench

Valid/ready stream transmitter that drives the slave-side (s_valid/s_ready/s_data) port of the team's FIFO wrapper. On a start pulse, it emits a burst of incrementing data words with optional idle gaps between beats. It obeys backpressure without dropping or altering a word. It is used as the traffic source in FIFO bring-up and as a reusable producer in datapath tests.

---
 rtl/kim_stream_src.sv | 114 +++++++++++
 tb/tb_kim_stream_src.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kim_stream_src.sv
`default_nettype none
// ============================================================================
//  Module   : kim_stream_src
//  Purpose  : Valid/ready burst source emitting incrementing words with
//             optional idle gaps between beats; honours backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module kim_stream_src #(
    parameter int FIFO_DATA_LENGTH = 32,
    parameter int LEN_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        burst_len,
    input  logic [LEN_WIDTH-1:0]        gap_len,
    input  logic [FIFO_DATA_LENGTH-1:0] seed,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [FIFO_DATA_LENGTH-1:0] m_data,
    output logic                        busy,
    output logic                        done,
    output logic [LEN_WIDTH-1:0]        beat_cnt
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_send = 2'd1;
    localparam logic [1:0] c_gap  = 2'd2;

    localparam logic [LEN_WIDTH-1:0]        c_len_one  = LEN_WIDTH'(1);
    localparam logic [FIFO_DATA_LENGTH-1:0] c_data_one = FIFO_DATA_LENGTH'(1);

    logic [1:0]                  r_state;
    logic                        r_m_valid;
    logic [FIFO_DATA_LENGTH-1:0] r_m_data;
    logic                        r_busy;
    logic                        r_done;
    logic [LEN_WIDTH-1:0]        r_beat_cnt;
    logic [LEN_WIDTH-1:0]        r_remaining;
    logic [LEN_WIDTH-1:0]        r_gap_len;
    logic [LEN_WIDTH-1:0]        r_gap_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_idle;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_beat_cnt  <= '0;
            r_remaining <= '0;
            r_gap_len   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_beat_cnt  <= '0;
                        r_gap_len   <= gap_len;
                        r_m_data    <= seed;
                        r_remaining <= burst_len;
                        if (burst_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state   <= c_send;
                            r_m_valid <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                c_send: begin
                    // Everything holds while the word waits for m_ready.
                    if (r_m_valid && m_ready) begin
                        r_beat_cnt  <= r_beat_cnt + c_len_one;
                        r_remaining <= r_remaining - c_len_one;
                        r_m_data    <= r_m_data + c_data_one;
                        if (r_remaining == c_len_one) begin
                            r_state   <= c_idle;
                            r_m_valid <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (r_gap_len != '0) begin
                            r_state   <= c_gap;
                            r_m_valid <= 1'b0;
                            r_gap_cnt <= r_gap_len;
                        end
                    end
                end
                c_gap: begin
                    // Leaving on count 1 gives exactly gap_len idle cycles.
                    r_gap_cnt <= r_gap_cnt - c_len_one;
                    if (r_gap_cnt == c_len_one) begin
                        r_state   <= c_send;
                        r_m_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_idle;
                    r_m_valid <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_kim_stream_src.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kim_stream_src
//  Purpose  : Self-checking bench for kim_stream_src against a word-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kim_stream_src;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  burst_len = '0;
    logic [7:0]  gap_len = '0;
    logic [31:0] seed = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        busy;
    logic        done;
    logic [7:0]  beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_got[$];
    bit          q_vld[$];

    kim_stream_src #(.FIFO_DATA_LENGTH(32), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .gap_len(gap_len), .seed(seed), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [31:0] s, input logic [7:0] len, input logic [7:0] g);
        start = 1'b1; seed = s; burst_len = len; gap_len = g;
        tick();
        start = 1'b0;
    endtask

    // Stimulus/monitor: drives m_ready, logs valid per cycle and accepted words
    // until done shows up or the bound runs out.
    task automatic collect(input int bound, input bit rnd, output int n_cyc,
                           output bit done_seen, output bit proto_ok);
        bit          pend;
        logic [31:0] pdata;
        pend = 1'b0; pdata = '0; proto_ok = 1'b1; done_seen = 1'b0; n_cyc = 0;
        while (n_cyc < bound) begin
            if (done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            if (pend && !(m_valid === 1'b1 && m_data === pdata)) proto_ok = 1'b0;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            q_vld.push_back(m_valid);
            if (m_valid && m_ready) q_got.push_back(m_data);
            pend  = m_valid && !m_ready;
            pdata = m_data;
            tick();
            n_cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({m_valid, m_data, busy, done, beat_cnt} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset: valid=%b data=%h busy=%b done=%b cnt=%0d required all zero",
                     m_valid, m_data, busy, done, beat_cnt);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int n; bit ds, pok;
        q_got.delete(); q_vld.delete();
        m_ready = 1'b1;
        drive_start(32'h10, 8'd4, 8'd0);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h10 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b data=%h busy=%b required 1 00000010 1", m_valid, m_data, busy);
        end
        collect(20, 1'b0, n, ds, pok);
        n_checks++;
        if (!ds || n != 4) begin
            n_fail++;
            $display("FAIL b2b_latency: done_seen=%b cycles=%0d required 1 4", ds, n);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= q_got.size() || q_got[i] !== 32'h10 + 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %h required %h", i,
                         (i < q_got.size()) ? q_got[i] : 32'hx, 32'h10 + 32'(i));
            end
        end
        n_checks++;
        if (beat_cnt !== 8'd4 || busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: cnt=%0d busy=%b valid=%b required 4 0 0", beat_cnt, busy, m_valid);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_width: done=%b required 0", done);
        end
    endtask

    task automatic test_backpressure();
        bit          pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bit          pend, stable_ok;
        logic [31:0] pdata;
        q_got.delete();
        pend = 1'b0; pdata = '0; stable_ok = 1'b1;
        drive_start(32'hA0, 8'd3, 8'd0);
        for (int p = 0; p < 6; p++) begin
            if (pend && !(m_valid === 1'b1 && m_data === pdata)) stable_ok = 1'b0;
            m_ready = pat[p];
            if (m_valid && m_ready) q_got.push_back(m_data);
            pend  = m_valid && !m_ready;
            pdata = m_data;
            tick();
        end
        n_checks++;
        if (!stable_ok) begin
            n_fail++;
            $display("FAIL bp_stable: stable=%b required 1", stable_ok);
        end
        n_checks++;
        if (q_got.size() != 3 || q_got[0] !== 32'hA0 || q_got[1] !== 32'hA1 || q_got[2] !== 32'hA2) begin
            n_fail++;
            $display("FAIL bp_words: count=%0d required 3 words A0 A1 A2", q_got.size());
        end
        n_checks++;
        if (done !== 1'b1 || beat_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL bp_done: done=%b cnt=%0d required 1 3", done, beat_cnt);
        end
        m_ready = 1'b1;
        tick();
    endtask

    task automatic test_gaps_wrap();
        int n; bit ds, pok;
        bit exp_vld[$];
        q_got.delete(); q_vld.delete();
        for (int b = 0; b < 3; b++) begin
            exp_vld.push_back(1'b1);
            if (b < 2) repeat (2) exp_vld.push_back(1'b0);
        end
        drive_start(32'hFFFF_FFFE, 8'd3, 8'd2);
        collect(40, 1'b0, n, ds, pok);
        n_checks++;
        if (!ds || q_vld.size() != exp_vld.size()) begin
            n_fail++;
            $display("FAIL gap_len: done_seen=%b cycles=%0d required 1 %0d", ds, q_vld.size(), exp_vld.size());
        end
        for (int i = 0; i < exp_vld.size() && i < q_vld.size(); i++) begin
            n_checks++;
            if (q_vld[i] !== exp_vld[i]) begin
                n_fail++;
                $display("FAIL gap_valid%0d: got %b required %b", i, q_vld[i], exp_vld[i]);
            end
        end
        n_checks++;
        if (q_got.size() != 3 || q_got[0] !== 32'hFFFF_FFFE || q_got[1] !== 32'hFFFF_FFFF ||
            q_got[2] !== 32'h0) begin
            n_fail++;
            $display("FAIL gap_wrap_words: count=%0d required FFFFFFFE FFFFFFFF 00000000", q_got.size());
        end
    endtask

    task automatic test_zero_len();
        drive_start(32'h55, 8'd0, 8'd0);
        n_checks++;
        if (done !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || beat_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_len: done=%b valid=%b busy=%b cnt=%0d required 1 0 0 0",
                     done, m_valid, busy, beat_cnt);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_after: done=%b valid=%b required 0 0", done, m_valid);
        end
    endtask

    task automatic test_start_busy();
        int n; bit ds, pok;
        q_got.delete(); q_vld.delete();
        m_ready = 1'b1;
        drive_start(32'h50, 8'd5, 8'd1);
        if (m_valid) q_got.push_back(m_data);
        start = 1'b1; seed = 32'h99; burst_len = 8'd2; gap_len = 8'd0;
        tick();
        start = 1'b0;
        collect(60, 1'b0, n, ds, pok);
        n_checks++;
        if (!ds || q_got.size() != 5 || beat_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL busy_start: done_seen=%b words=%0d cnt=%0d required 1 5 5", ds, q_got.size(), beat_cnt);
        end
        for (int i = 0; i < 5 && i < q_got.size(); i++) begin
            n_checks++;
            if (q_got[i] !== 32'h50 + 32'(i)) begin
                n_fail++;
                $display("FAIL busy_word%0d: got %h required %h", i, q_got[i], 32'h50 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n; bit ds, pok, done_bad;
        q_got.delete(); q_vld.delete();
        m_ready = 1'b1;
        drive_start(32'h30, 8'd6, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 32'h0 || busy !== 1'b0 || beat_cnt !== 8'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b data=%h busy=%b cnt=%0d done=%b required all zero",
                     m_valid, m_data, busy, beat_cnt, done);
        end
        rst = 1'b1;
        done_bad = 1'b0;
        repeat (3) begin
            tick();
            if (done !== 1'b0 || m_valid !== 1'b0) done_bad = 1'b1;
        end
        n_checks++;
        if (done_bad) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: done_or_valid_seen=%b required 0", done_bad);
        end
        drive_start(32'h7, 8'd2, 8'd0);
        collect(20, 1'b0, n, ds, pok);
        n_checks++;
        if (!ds || q_got.size() != 2 || q_got[0] !== 32'h7 || q_got[1] !== 32'h8) begin
            n_fail++;
            $display("FAIL rst_mid_restart: done_seen=%b words=%0d required 1 2 (07 08)", ds, q_got.size());
        end
    endtask

    task automatic test_fifo_loopback();
        logic [31:0] fifo[$];
        logic [31:0] outq[$];
        logic [31:0] pdata, s0;
        int          cyc, stalled;
        bit          pend, stable_ok;
        s0 = $urandom;
        cyc = 0; stalled = 0; pend = 1'b0; pdata = '0; stable_ok = 1'b1;
        drive_start(s0, 8'd8, 8'd0);
        while (outq.size() < 8 && cyc < 200) begin
            if (pend && !(m_valid === 1'b1 && m_data === pdata)) stable_ok = 1'b0;
            m_ready = (fifo.size() < 4);
            if (m_valid && !m_ready) stalled++;
            if (cyc >= 10 && fifo.size() > 0) outq.push_back(fifo.pop_front());
            if (m_valid && m_ready) fifo.push_back(m_data);
            pend  = m_valid && !m_ready;
            pdata = m_data;
            tick();
            cyc++;
        end
        n_checks++;
        if (outq.size() != 8 || stalled == 0 || !stable_ok) begin
            n_fail++;
            $display("FAIL fifo_loop: words=%0d stalls=%0d stable=%b required 8 >0 1", outq.size(), stalled, stable_ok);
        end
        for (int i = 0; i < outq.size(); i++) begin
            n_checks++;
            if (outq[i] !== s0 + 32'(i)) begin
                n_fail++;
                $display("FAIL fifo_word%0d: got %h required %h", i, outq[i], s0 + 32'(i));
            end
        end
        n_checks++;
        if (busy !== 1'b0 || beat_cnt !== 8'd8) begin
            n_fail++;
            $display("FAIL fifo_end: busy=%b cnt=%0d required 0 8", busy, beat_cnt);
        end
    endtask

    task automatic test_random();
        int          n, len;
        bit          ds, pok;
        logic [31:0] s0;
        for (int it = 0; it < 8; it++) begin
            q_got.delete(); q_vld.delete();
            s0  = $urandom;
            len = $urandom_range(0, 6);
            drive_start(s0, 8'(len), 8'($urandom_range(0, 3)));
            collect(300, 1'b1, n, ds, pok);
            n_checks++;
            if (!ds || !pok || q_got.size() != len || beat_cnt !== 8'(len) || m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d: done_seen=%b proto=%b words=%0d cnt=%0d valid=%b required 1 1 %0d %0d 0",
                         it, ds, pok, q_got.size(), beat_cnt, m_valid, len, len);
            end
            for (int i = 0; i < q_got.size() && i < len; i++) begin
                n_checks++;
                if (q_got[i] !== s0 + 32'(i)) begin
                    n_fail++;
                    $display("FAIL rand%0d_word%0d: got %h required %h", it, i, q_got[i], s0 + 32'(i));
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        do_reset();
        test_back_to_back();
        test_backpressure();
        test_gaps_wrap();
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        test_fifo_loopback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
